pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Program-counter and call-stack stage directly downstream of the 8-bit equality comparator in the Chip-8 core.
- Consumes the comparator's eq/neq outputs to resolve the conditional skips 3XNN, 4XNN, 5XY0 and 9XY0.
- Also executes the jumps (1NNN, BNNN), calls (2NNN) and returns (00EE).
- Presents the fetch address to instruction fetch, with a one-command-at-a-time valid/ready handshake from the decoder.

Parameters:
- RESET_PC, 12'h200, PC value loaded on reset.
- STACK_DEPTH, 16, number of return-address entries (power of two, ≤16).

Ports:
- clk  in  1  system clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- cmd_valid  in  1  decoder presents a command.
- cmd_ready  out  1  block can accept a command.
- cmd_op  in  3  0 NEXT, 1 SKIP_EQ, 2 SKIP_NE, 3 JUMP, 4 JUMP_V0, 5 CALL, 6 RET, 7 reserved.
- target  in  12  NNN address field.
- v0  in  8  current V0 register value, used by JUMP_V0.
- eq  in  1  comparator equal output.
- neq  in  1  comparator not-equal output.
- pc  out  12  current program counter.
- sp  out  5  stack entries in use (0..STACK_DEPTH).
- done  out  1  one-cycle pulse when a command retires.
- stack_overflow  out  1  sticky fault flag.
- stack_underflow  out  1  sticky fault flag.

Behaviour:
- Reset is asynchronous, active-high. It forces:
  - pc=RESET_PC, sp=0, state IDLE, cmd_ready=1, done=0, both fault flags 0.
  - Stack contents are not reset.
- Reset mid-command aborts the command: no push, no pc change beyond the reset value, no done pulse.
- FSM states: IDLE, POP, UPDATE.
- IDLE:
  - cmd_ready=1.
  - Accept occurs on a clk edge where cmd_valid=1.
  - On accept, latch cmd_op, target, v0, eq and neq. Inputs may change after the accept edge.
  - Go to POP if op=RET and sp≠0; otherwise go to UPDATE.
- POP (RET only):
  - Read stack[sp-1] into a return register and decrement sp.
  - Go to UPDATE.
- UPDATE:
  - cmd_ready=0.
  - Next-pc is computed and loaded at the end of this cycle; done is high during this cycle; return to IDLE.
- Latency, accept edge to pc updated: 2 cycles for all ops except a successful RET, which takes 3.
- cmd_ready is 0 in POP and UPDATE. The earliest back-to-back accept is the edge after done.
- Next-pc rules (all arithmetic is modulo 2^12; pc wraps 0xFFE→0x000, 0xFFF→0x001):
  - NEXT / reserved: pc+2.
  - SKIP_EQ: pc+4 if latched eq=1, else pc+2.
  - SKIP_NE: pc+4 if latched neq=1, else pc+2.
  - JUMP: target.
  - JUMP_V0: target + zero-extended v0, 12-bit truncated.
  - CALL with sp<STACK_DEPTH: stack[sp]=pc+2, sp+1, pc=target. The push is written in UPDATE.
  - CALL with sp=STACK_DEPTH: no push, sp unchanged, stack_overflow←1, pc+2.
  - RET with sp≠0: pc=return register.
  - RET with sp=0: skips POP, stack_underflow←1, sp stays 0, pc+2.
- Skip decision uses eq when op=SKIP_EQ and neq when op=SKIP_NE only. If eq and neq are both 1 or both 0, each op still obeys its own input.
- Fault flags are sticky and cleared only by rst. Commands continue to execute after a fault.
- pc, sp and flags are registered outputs. done is registered and asserted exactly one cycle per accepted command.

Test Plan:
- Reset then NEXT ×3 -> pc 0x200→0x202→0x204→0x206; done pulses once per command, 2 cycles after each accept.
- SKIP_EQ with eq=1 at pc=0x206 -> pc=0x20A. SKIP_NE with neq=0 -> pc=0x20C. Dropping eq on the cycle after accept does not change the result.
- JUMP target=0x3F0 -> 0x3F0. JUMP_V0 target=0xFF0, v0=0x20 -> pc=0x010 (wrap). NEXT at 0xFFE -> 0x000.
- CALL 0x400 at pc=0x210 -> pc=0x400, sp=1. CALL 0x500 -> sp=2. RET -> pc=0x402, sp=1, 3-cycle latency. RET -> pc=0x212, sp=0.
- 16 CALLs then a 17th -> stack_overflow=1, sp=16, pc advances by 2. 17 RETs -> the first 16 unwind correctly, the 17th sets stack_underflow=1 and pc+2. Flags stay set until rst.
- Assert rst asynchronously during the POP of a RET (not clock-aligned) -> pc=0x200, sp=0, flags=0, no done pulse; cmd_ready=1 immediately.

Source files
------------

// File: rtl/pc_sequencer.sv
// Chip-8 program counter and call stack, fed by the equality comparator.
// Resolves skips, jumps, calls and returns one command at a time.
module pc_sequencer #(
    parameter logic [11:0] RESET_PC    = 12'h200,
    parameter int          STACK_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [2:0]  cmd_op,
    input  logic [11:0] target,
    input  logic [7:0]  v0,
    input  logic        eq,
    input  logic        neq,
    output logic [11:0] pc,
    output logic [4:0]  sp,
    output logic        done,
    output logic        stack_overflow,
    output logic        stack_underflow
);

    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam logic [4:0] DEPTH = 5'(STACK_DEPTH);

    localparam logic [2:0] OP_SKEQ = 3'd1;
    localparam logic [2:0] OP_SKNE = 3'd2;
    localparam logic [2:0] OP_JUMP = 3'd3;
    localparam logic [2:0] OP_JV0  = 3'd4;
    localparam logic [2:0] OP_CALL = 3'd5;
    localparam logic [2:0] OP_RET  = 3'd6;

    typedef enum logic [1:0] {
        IDLE,
        POP,
        UPDATE
    } state_t;

    state_t      state_q, state_d;
    logic [11:0] pc_q, pc_d;
    logic [4:0]  sp_q, sp_d;
    logic        ovf_q, ovf_d;
    logic        unf_q, unf_d;
    logic        done_q;
    logic [2:0]  op_q;
    logic [11:0] target_q;
    logic [7:0]  v0_q;
    logic        eq_q, neq_q;
    logic        ret_ok_q;
    logic [11:0] ret_q;
    logic [11:0] stack_q [STACK_DEPTH];
    logic [11:0] pc_inc2, pc_inc4;
    logic        accept;
    logic        push;

    assign pc_inc2   = pc_q + 12'd2;
    assign pc_inc4   = pc_q + 12'd4;
    assign cmd_ready = (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        sp_d    = sp_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = (cmd_op == OP_RET && sp_q != 5'd0) ? POP : UPDATE;
                end
            end
            POP: begin
                sp_d    = sp_q - 5'd1;
                state_d = UPDATE;
            end
            UPDATE: begin
                state_d = IDLE;
                pc_d    = pc_inc2;
                unique case (op_q)
                    OP_SKEQ: if (eq_q) pc_d = pc_inc4;
                    OP_SKNE: if (neq_q) pc_d = pc_inc4;
                    OP_JUMP: pc_d = target_q;
                    OP_JV0:  pc_d = target_q + {4'd0, v0_q};
                    OP_CALL: begin
                        if (sp_q < DEPTH) begin
                            push = 1'b1;
                            sp_d = sp_q + 5'd1;
                            pc_d = target_q;
                        end else begin
                            ovf_d = 1'b1;
                        end
                    end
                    OP_RET: begin
                        if (ret_ok_q) pc_d = ret_q;
                        else unf_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            pc_q     <= RESET_PC;
            sp_q     <= 5'd0;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
            done_q   <= 1'b0;
            op_q     <= 3'd0;
            target_q <= 12'd0;
            v0_q     <= 8'd0;
            eq_q     <= 1'b0;
            neq_q    <= 1'b0;
            ret_ok_q <= 1'b0;
            ret_q    <= 12'd0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            sp_q    <= sp_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= (state_d == UPDATE);
            if (accept) begin
                op_q     <= cmd_op;
                target_q <= target;
                v0_q     <= v0;
                eq_q     <= eq;
                neq_q    <= neq;
                ret_ok_q <= (sp_q != 5'd0);
            end
            if (state_q == POP) begin
                ret_q <= stack_q[sp_q[AW-1:0] - AW'(1)];
            end
        end
    end

    // Return-address storage is deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            stack_q[sp_q[AW-1:0]] <= pc_inc2;
        end
    end

    assign pc              = pc_q;
    assign sp              = sp_q;
    assign done            = done_q;
    assign stack_overflow  = ovf_q;
    assign stack_underflow = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer; expected results are queued at accept
// time and compared by a monitor on the cycle after each done pulse.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = 3'd0;
    logic [11:0] target = 12'd0;
    logic [7:0]  v0 = 8'd0;
    logic        eq = 1'b0;
    logic        neq = 1'b0;
    logic [11:0] pc;
    logic [4:0]  sp;
    logic        done;
    logic        stack_overflow;
    logic        stack_underflow;

    pc_sequencer #(
        .RESET_PC   (12'h200),
        .STACK_DEPTH(16)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .target         (target),
        .v0             (v0),
        .eq             (eq),
        .neq            (neq),
        .pc             (pc),
        .sp             (sp),
        .done           (done),
        .stack_overflow (stack_overflow),
        .stack_underflow(stack_underflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [11:0] pc;
        logic [4:0]  sp;
        logic        ovf;
        logic        unf;
        int          lat;
        int          acc;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;
    int   exp_dones = 0;
    bit   pending = 0;
    bit   prev_done = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act == req) passes++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (pending) begin
            pending = 0;
            if (q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                e = q.pop_front();
                chk("pc", int'(pc), int'(e.pc));
                chk("sp", int'(sp), int'(e.sp));
                chk("overflow", int'(stack_overflow), int'(e.ovf));
                chk("underflow", int'(stack_underflow), int'(e.unf));
                chk("latency", cyc - e.acc + 1, e.lat);
            end
        end
        if (done) begin
            chk("done_single", int'(prev_done), 0);
            pending = 1;
            done_cnt++;
        end
        prev_done = done;
    end

    task automatic issue(input logic [2:0] op, input logic [11:0] tgt,
                         input logic [7:0] v, input logic e, input logic n,
                         input bit flip, input logic [11:0] epc,
                         input logic [4:0] esp, input logic eovf,
                         input logic eunf, input int elat);
        exp_t x;
        int   w;
        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!cmd_ready) begin
            chk("ready_timeout", 0, 1);
            return;
        end
        cmd_valid = 1'b1;
        cmd_op    = op;
        target    = tgt;
        v0        = v;
        eq        = e;
        neq       = n;
        x = '{epc, esp, eovf, eunf, elat, cyc + 1};
        @(posedge clk);
        q.push_back(x);
        exp_dones++;
        @(negedge clk);
        cmd_valid = 1'b0;
        if (flip) begin
            eq  = ~eq;
            neq = ~neq;
        end
        target = ~target;
        v0     = ~v0;
        cmd_op = 3'd0;
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, "_pc"}, int'(pc), 'h200);
        chk({tag, "_sp"}, int'(sp), 0);
        chk({tag, "_ready"}, int'(cmd_ready), 1);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_ovf"}, int'(stack_overflow), 0);
        chk({tag, "_unf"}, int'(stack_underflow), 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] rpc;
        int          idx;
        int          w;

        repeat (2) @(negedge clk);
        check_reset_state("reset");
        rst = 1'b0;

        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h202, 5'd0, 0, 0, 2);
        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h204, 5'd0, 0, 0, 2);
        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h206, 5'd0, 0, 0, 2);
        issue(3'd1, 12'h000, 8'h00, 1, 0, 1, 12'h20A, 5'd0, 0, 0, 2);
        issue(3'd2, 12'h000, 8'h00, 1, 0, 1, 12'h20C, 5'd0, 0, 0, 2);
        issue(3'd2, 12'h000, 8'h00, 1, 1, 0, 12'h210, 5'd0, 0, 0, 2);

        issue(3'd5, 12'h400, 8'h00, 0, 0, 0, 12'h400, 5'd1, 0, 0, 2);
        issue(3'd5, 12'h500, 8'h00, 0, 0, 0, 12'h500, 5'd2, 0, 0, 2);
        issue(3'd6, 12'h000, 8'h00, 0, 0, 0, 12'h402, 5'd1, 0, 0, 3);
        issue(3'd6, 12'h000, 8'h00, 0, 0, 0, 12'h212, 5'd0, 0, 0, 3);

        issue(3'd3, 12'h3F0, 8'h00, 0, 0, 0, 12'h3F0, 5'd0, 0, 0, 2);
        issue(3'd4, 12'hFF0, 8'h20, 0, 0, 0, 12'h010, 5'd0, 0, 0, 2);
        issue(3'd3, 12'hFFE, 8'h00, 0, 0, 0, 12'hFFE, 5'd0, 0, 0, 2);
        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h000, 5'd0, 0, 0, 2);
        issue(3'd7, 12'h123, 8'h00, 0, 0, 0, 12'h002, 5'd0, 0, 0, 2);
        issue(3'd3, 12'hFFF, 8'h00, 0, 0, 0, 12'hFFF, 5'd0, 0, 0, 2);
        issue(3'd1, 12'h000, 8'h00, 1, 1, 0, 12'h003, 5'd0, 0, 0, 2);
        issue(3'd1, 12'h000, 8'h00, 0, 1, 0, 12'h005, 5'd0, 0, 0, 2);
        issue(3'd3, 12'h100, 8'h00, 0, 0, 0, 12'h100, 5'd0, 0, 0, 2);

        for (int i = 0; i < 16; i++) begin
            issue(3'd5, 12'(12'h600 + 4 * i), 8'h00, 0, 0, 0,
                  12'(12'h600 + 4 * i), 5'(i + 1), 0, 0, 2);
        end
        issue(3'd5, 12'h7F0, 8'h00, 0, 0, 0, 12'h63E, 5'd16, 1, 0, 2);
        for (int k = 1; k <= 16; k++) begin
            idx = 16 - k;
            rpc = (idx == 0) ? 12'h102 : 12'(12'h600 + 4 * (idx - 1) + 2);
            issue(3'd6, 12'h000, 8'h00, 0, 0, 0, rpc, 5'(idx), 1, 0, 3);
        end
        issue(3'd6, 12'h000, 8'h00, 0, 0, 0, 12'h104, 5'd0, 1, 1, 2);
        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h106, 5'd0, 1, 1, 2);
        issue(3'd5, 12'h700, 8'h00, 0, 0, 0, 12'h700, 5'd1, 1, 1, 2);

        @(negedge clk);
        w = 0;
        while (!cmd_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        chk("abort_ready", int'(cmd_ready), 1);
        cmd_valid = 1'b1;
        cmd_op    = 3'd6;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_reset_state("abort");
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        repeat (2) @(negedge clk);
        check_reset_state("abort_hold");
        rst = 1'b0;

        issue(3'd0, 12'h000, 8'h00, 0, 0, 0, 12'h202, 5'd0, 0, 0, 2);

        w = 0;
        while ((q.size() != 0 || pending) && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(negedge clk);
        chk("queue_drained", q.size(), 0);
        chk("done_count", done_cnt, exp_dones);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
